uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Buffered UART peripheral for the 0x2000_2000 peripheral slot, replacing the single-byte UART.
- Fixed 8-N-1 framing with a runtime-programmable baud divisor.
- Parametrised TX and RX FIFOs, sticky error flags and a maskable interrupt.
- Attaches to the CPU address-decode bus: combinational read data, single-cycle read and write strobes.

Parameters:
- FREQ_HZ, 12000000, system clock frequency in Hz.
- BAUDS, 115200, reset baud rate; reset divisor = FREQ_HZ/BAUDS, rounded down.
- TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- sel_i  in  1  block selected, from the address decoder.
- wr_i  in  1  write strobe; qualified by sel_i.
- rd_i  in  1  read strobe; qualified by sel_i; one pulse per CPU read.
- addr_i  in  4  byte offset; only 0x0, 0x4, 0x8 and 0xC are decoded.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data; combinational from addr_i and current state.
- rx_i  in  1  serial input; asynchronous to clk.
- tx_o  out  1  serial output.
- irq_o  out  1  interrupt request; registered, level.

Behaviour:
- Reset (asynchronous on reset_n_i low):
  - tx_o=1, irq_o=0.
  - Both FIFOs empty; sticky flags and CTRL cleared.
  - BAUD_DIV = FREQ_HZ/BAUDS.
  - TX and RX state machines return to IDLE; any frame in progress is abandoned and tx_o goes to 1 immediately.
- Register map:
  - 0x0 DATA
    - Write: pushes wdata_i[7:0] into the TX FIFO. If the FIFO is full the write is dropped and no flag is set.
    - Read: rdata_o = {24'd0, RX head}, or 0 if the RX FIFO is empty.
    - A read strobe pops the RX FIFO only when it is non-empty.
  - 0x4 STATUS (read)
    - bit0 tx_full.
    - bit1 rx_valid (RX FIFO non-empty).
    - bit2 tx_empty.
    - bit3 rx_overflow, sticky.
    - bit4 frame_error, sticky.
    - bit5 tx_busy (shifter active or TX FIFO non-empty).
  - 0x4 STATUS (write): writing 1 to bit3 or bit4 clears that flag; all other bits are ignored.
  - 0x8 CTRL (read/write): bit0 rx_irq_en, bit1 tx_irq_en; all other bits read 0.
  - 0xC BAUD_DIV (read/write): 16-bit divisor in bits [15:0]. A written value below 4 is stored as 4. The new value takes effect at the next start bit; the frame in progress is unaffected.
  - Undecoded offsets read 0; writes to them are ignored.
- Strobe qualification: wr_i and rd_i have no effect unless sel_i=1.
- FIFOs:
  - Circular, with separate read and write pointers plus a count (log2(DEPTH)+1 bits).
  - Push and pop in the same cycle: both happen and the count is unchanged; this also applies when the FIFO is full.
  - Pointers wrap modulo DEPTH.
- TX state machine, states IDLE, START, DATA, STOP:
  - IDLE: when the TX FIFO is non-empty, pop the head and go to START on the next cycle.
  - Each state lasts BAUD_DIV clocks.
  - DATA shifts 8 bits LSB first.
  - After STOP, return to IDLE; back-to-back bytes have no gap cycles.
- RX path:
  - rx_i passes through a 2-flop synchronizer.
  - RX states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 1->0 edge enters START.
  - START: sample at BAUD_DIV/2. If the line is high, it is a glitch; return to IDLE. Otherwise continue.
  - DATA: sample every BAUD_DIV clocks, 8 bits, LSB first.
  - STOP: sample the stop bit.
    - Stop bit low: set frame_error and discard the byte.
    - Stop bit high and RX FIFO full: set rx_overflow and drop the new byte; FIFO contents are untouched.
    - Stop bit high and RX FIFO not full: push the byte, or push and pop together if a CPU pop lands in the same cycle.
  - Return to IDLE after the stop sample.
- Sticky flags: when a set and a W1C clear land in the same cycle, the set wins.
- Interrupt: irq_o <= (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty & ~tx_busy). It is registered, so it trails the underlying condition by one clock.

Test Plan:
- FREQ_HZ=12000000, BAUDS=1000000 (BAUD_DIV=12); write 0x41 to DATA -> tx_o low 12 clocks, then bits 1,0,0,0,0,0,1,0, then high 12 clocks; tx_busy=1 throughout the frame; tx_empty=1 two clocks after the write.
- Write 17 bytes with TX_DEPTH=16 and the shifter busy -> tx_full=1 after byte 17 (16 queued, 1 in the shifter); byte 18 dropped; line shows exactly 17 frames in order.
- Drive 17 valid frames 0x00..0x10 with no reads, RX_DEPTH=16 -> rx_overflow=1; reads return 0x00..0x0F, then rx_valid=0 and DATA reads 0; write 0x08 to STATUS -> bit3=0.
- Frame 0x55 with stop bit held low -> frame_error=1, rx_valid stays 0; a 3-clock low glitch on rx_i -> no byte, no error.
- CTRL=0x1, receive 0xA5 -> irq_o=1; read DATA returns 0xA5 -> irq_o=0 the clock after the pop.
- Write BAUD_DIV=2 -> reads back 4; assert reset_n_i mid-TX-frame -> tx_o=1 immediately, BAUD_DIV=12, STATUS=0x04.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: 8-N-1 UART with TX/RX FIFOs, sticky error flags and a maskable interrupt
module uart_fifo #(
  parameter int FREQ_HZ  = 12000000,
  parameter int BAUDS    = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(FREQ_HZ / BAUDS);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [7:0] rx_mem_q [RX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TAW:0] tx_cnt_q, tx_cnt_d;
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RAW:0] rx_cnt_q, rx_cnt_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic ovf_q, ovf_d, ferr_q, ferr_d, irq_q, irq_d;
  logic [1:0] txs_q, txs_d, rxs_q, rxs_d;
  logic [15:0] txb_q, txb_d, txdiv_q, txdiv_d, rxb_q, rxb_d, rxdiv_q, rxdiv_d;
  logic [7:0] txsh_q, txsh_d, rxsh_q, rxsh_d;
  logic [2:0] txbit_q, txbit_d, rxbit_q, rxbit_d, sync_q, sync_d;
  logic tx_q, tx_d;
  logic wr_en, rd_en, tx_push, tx_pop, rx_push, rx_pop, set_ovf, set_ferr;
  logic tx_full, tx_empty, rx_full, rx_valid, tx_busy, tx_end, rx_end, rx_s, rx_p;
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:16];
  assign tx_o = tx_q;
  assign irq_o = irq_q;
  // FIFO status and bus strobe decode; a full TX FIFO still accepts a write when the shifter pops
  always_comb begin
    tx_full = tx_cnt_q[TAW];
    tx_empty = tx_cnt_q == '0;
    rx_full = rx_cnt_q[RAW];
    rx_valid = rx_cnt_q != '0;
    tx_busy = (txs_q != S_IDLE) | ~tx_empty;
    wr_en = sel_i & wr_i;
    rd_en = sel_i & rd_i;
    tx_push = wr_en & (addr_i == 4'h0) & (~tx_full | tx_pop);
    rx_pop = rd_en & (addr_i == 4'h0) & rx_valid;
    rx_s = sync_q[1];
    rx_p = sync_q[2];
  end
  // TX shifter: each state lasts the divisor latched when its byte was popped
  always_comb begin
    txs_d = txs_q;
    txb_d = txb_q + 16'd1;
    txdiv_d = txdiv_q;
    txsh_d = txsh_q;
    txbit_d = txbit_q;
    tx_pop = 1'b0;
    tx_end = txb_q == txdiv_q - 16'd1;
    case (txs_q)
      S_IDLE: begin
        txb_d = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          txs_d = S_START;
        end
      end
      S_START: if (tx_end) begin
        txs_d = S_DATA;
        txb_d = '0;
        txbit_d = '0;
      end
      S_DATA: if (tx_end) begin
        txb_d = '0;
        txbit_d = txbit_q + 3'd1;
        txsh_d = txsh_q >> 1;
        if (txbit_q == 3'd7) txs_d = S_STOP;
      end
      default: if (tx_end) begin
        txb_d = '0;
        txs_d = S_IDLE;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          txs_d = S_START;
        end
      end
    endcase
    if (tx_pop) begin
      txsh_d = tx_mem_q[tx_rp_q];
      txdiv_d = div_q;
      txb_d = '0;
    end
    tx_d = txs_d == S_START ? 1'b0 : txs_d == S_DATA ? txsh_d[0] : 1'b1;
  end
  // RX receiver: start-bit validation at half a bit, then one sample per bit period
  always_comb begin
    sync_d = {sync_q[1:0], rx_i};
    rxs_d = rxs_q;
    rxb_d = rxb_q + 16'd1;
    rxdiv_d = rxdiv_q;
    rxsh_d = rxsh_q;
    rxbit_d = rxbit_q;
    rx_push = 1'b0;
    set_ovf = 1'b0;
    set_ferr = 1'b0;
    rx_end = rxb_q == rxdiv_q - 16'd1;
    case (rxs_q)
      S_IDLE: begin
        rxb_d = '0;
        if (rx_p & ~rx_s) begin
          rxs_d = S_START;
          rxdiv_d = div_q;
        end
      end
      S_START: if (rxb_q == (rxdiv_q >> 1)) begin
        rxb_d = '0;
        rxbit_d = '0;
        rxs_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rxb_d = '0;
        rxsh_d = {rx_s, rxsh_q[7:1]};
        rxbit_d = rxbit_q + 3'd1;
        if (rxbit_q == 3'd7) rxs_d = S_STOP;
      end
      default: if (rx_end) begin
        rxs_d = S_IDLE;
        set_ferr = ~rx_s;
        set_ovf = rx_s & rx_full;
        rx_push = rx_s & ~rx_full;
      end
    endcase
  end
  // FIFO pointers/counts, registers, sticky flags (set beats clear) and interrupt
  always_comb begin
    tx_wp_d = tx_wp_q + TAW'(tx_push);
    tx_rp_d = tx_rp_q + TAW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    rx_wp_d = rx_wp_q + RAW'(rx_push);
    rx_rp_d = rx_rp_q + RAW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    ctrl_d = wr_en & (addr_i == 4'h8) ? wdata_i[1:0] : ctrl_q;
    div_d = ~(wr_en & (addr_i == 4'hC)) ? div_q : wdata_i[15:0] < 16'd4 ? 16'd4 : wdata_i[15:0];
    ovf_d = set_ovf | (ovf_q & ~(wr_en & (addr_i == 4'h4) & wdata_i[3]));
    ferr_d = set_ferr | (ferr_q & ~(wr_en & (addr_i == 4'h4) & wdata_i[4]));
    irq_d = (ctrl_q[0] & rx_valid) | (ctrl_q[1] & tx_empty & ~tx_busy);
  end
  // Combinational register read-back
  always_comb begin
    rdata_o = addr_i == 4'h0 ? (rx_valid ? {24'd0, rx_mem_q[rx_rp_q]} : 32'd0)
            : addr_i == 4'h4 ? {26'd0, tx_busy, ferr_q, ovf_q, tx_empty, rx_valid, tx_full}
            : addr_i == 4'h8 ? {30'd0, ctrl_q}
            : addr_i == 4'hC ? {16'd0, div_q} : 32'd0;
  end
  // FIFO storage needs no reset; validity comes from the counts
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= wdata_i[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rxsh_q;
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      tx_cnt_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      rx_cnt_q <= '0;
      ctrl_q <= '0;
      div_q <= DIV_RST;
      ovf_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_q <= 1'b0;
      txs_q <= S_IDLE;
      txb_q <= '0;
      txdiv_q <= DIV_RST;
      txsh_q <= '0;
      txbit_q <= '0;
      tx_q <= 1'b1;
      rxs_q <= S_IDLE;
      rxb_q <= '0;
      rxdiv_q <= DIV_RST;
      rxsh_q <= '0;
      rxbit_q <= '0;
      sync_q <= 3'b111;
    end else begin
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      ctrl_q <= ctrl_d;
      div_q <= div_d;
      ovf_q <= ovf_d;
      ferr_q <= ferr_d;
      irq_q <= irq_d;
      txs_q <= txs_d;
      txb_q <= txb_d;
      txdiv_q <= txdiv_d;
      txsh_q <= txsh_d;
      txbit_q <= txbit_d;
      tx_q <= tx_d;
      rxs_q <= rxs_d;
      rxb_q <= rxb_d;
      rxdiv_q <= rxdiv_d;
      rxsh_q <= rxsh_d;
      rxbit_q <= rxbit_d;
      sync_q <= sync_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed checks of the buffered UART at BAUD_DIV=12
module tb_uart_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sel = 1'b0, wr = 1'b0, rd = 1'b0, rx = 1'b1;
  logic [3:0] addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic tx, irq;
  int total = 0, bad = 0;
  typedef struct {
    logic s, w, r;
    logic [3:0] a;
    logic [31:0] d;
    logic chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [21];
  uart_fifo #(.FREQ_HZ(12000000), .BAUDS(1000000), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .reset_n_i(reset_n), .sel_i(sel), .wr_i(wr), .rd_i(rd), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .rx_i(rx), .tx_o(tx), .irq_o(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic vec_t vw(input logic [3:0] a, input logic [31:0] d);
    return '{1'b1, 1'b1, 1'b0, a, d, 1'b0, 32'h0};
  endfunction
  function automatic vec_t vr(input logic [3:0] a, input logic [31:0] e);
    return '{1'b1, 1'b0, 1'b1, a, 32'h0, 1'b1, e};
  endfunction
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 sel = 1'b0; wr = 1'b0;
  endtask
  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 sel = 1'b0; rd = 1'b0;
  endtask
  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
  endtask
  task automatic send(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    rx = 1'b0;
    repeat (11) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = b[i];
      repeat (11) @(negedge clk);
    end
    @(negedge clk);
    rx = stopb;
    repeat (11) @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic get_frame(output logic [7:0] b, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    b = 8'h0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) return;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (12) @(negedge clk);
      b[k] = tx;
    end
    repeat (12) @(negedge clk);
    ok = tx === 1'b1;
  endtask
  initial begin
    logic [31:0] d;
    logic [9:0] fr;
    logic [7:0] got [17];
    logic okf [17];
    int mism;
    tbl[0] = vr(4'h4, 32'h04);
    tbl[1] = vr(4'h8, 32'h0);
    tbl[2] = vr(4'hC, 32'd12);
    tbl[3] = vr(4'h0, 32'h0);
    tbl[4] = vw(4'h8, 32'hFFFF_FFFF);
    tbl[5] = vr(4'h8, 32'h3);
    tbl[6] = vw(4'hC, 32'h2);
    tbl[7] = vr(4'hC, 32'h4);
    tbl[8] = vw(4'hC, 32'h0001_0005);
    tbl[9] = vr(4'hC, 32'h5);
    tbl[10] = vw(4'hC, 32'd12);
    tbl[11] = vr(4'hC, 32'd12);
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 32'h0};
    tbl[13] = vr(4'h8, 32'h3);
    tbl[14] = vw(4'h8, 32'h0);
    tbl[15] = vr(4'h8, 32'h0);
    tbl[16] = vw(4'h1, 32'h55);
    tbl[17] = vw(4'h4, 32'hFFFF_FFFF);
    tbl[18] = vr(4'h4, 32'h04);
    tbl[19] = vr(4'h2, 32'h0);
    tbl[20] = vr(4'hD, 32'h0);
    repeat (3) @(negedge clk);
    check("reset tx_o", 32'(tx), 32'h1);
    check("reset irq_o", 32'(irq), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      sel = tbl[i].s; wr = tbl[i].w; rd = tbl[i].r; addr = tbl[i].a; wdata = tbl[i].d;
      #1 if (tbl[i].chk) check($sformatf("vec%0d", i), rdata, tbl[i].exp);
      @(posedge clk);
      #1 sel = 1'b0; wr = 1'b0; rd = 1'b0;
    end
    check("irq after ctrl cleared", 32'(irq), 32'h0);
    // single frame 0x41, sampled every clock
    bus_wr(4'h0, 32'h41);
    peek(4'h4, d);
    check("tx_o idle one clock after write", 32'(tx), 32'h1);
    check("tx_empty 0 one clock after write", 32'(d[2]), 32'h0);
    peek(4'h4, d);
    check("tx_empty 1 two clocks after write", 32'(d[2]), 32'h1);
    fr = {1'b1, 8'h41, 1'b0};
    for (int b = 0; b < 10; b++) begin
      mism = 0;
      for (int k = 0; k < 12; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        #1 if (tx !== fr[b] || rdata[5] !== 1'b1) mism++;
      end
      check($sformatf("tx 0x41 bit%0d", b), 32'(mism), 32'h0);
    end
    peek(4'h4, d);
    check("status after frame", d, 32'h04);
    // 18 back-to-back writes: 17 accepted, 18th dropped
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          bus_wr(4'h0, 32'((i * 37 + 5) & 8'hFF));
          if (i == 16) begin
            peek(4'h4, d);
            check("tx_full after byte 17", 32'(d[0]), 32'h1);
          end
        end
        peek(4'h4, d);
        check("tx_full after byte 18", 32'(d[0]), 32'h1);
      end
      begin
        for (int j = 0; j < 17; j++) get_frame(got[j], okf[j]);
      end
    join
    for (int j = 0; j < 17; j++)
      check($sformatf("burst frame%0d", j), {23'd0, okf[j], got[j]}, {23'd0, 1'b1, 8'((j * 37 + 5) & 8'hFF)});
    mism = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) mism++;
    end
    check("no 18th frame", 32'(mism), 32'h0);
    peek(4'h4, d);
    check("status after burst", d, 32'h04);
    // RX overflow: 17 frames, 16 kept
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1);
    repeat (5) @(negedge clk);
    peek(4'h4, d);
    check("status rx overflow", d, 32'h0E);
    for (int i = 0; i < 16; i++) begin
      bus_rd(4'h0, d);
      check($sformatf("rx read%0d", i), d, 32'(i));
    end
    peek(4'h4, d);
    check("status rx drained", d, 32'h0C);
    bus_rd(4'h0, d);
    check("rx empty read", d, 32'h0);
    bus_wr(4'h4, 32'h08);
    peek(4'h4, d);
    check("overflow cleared", d, 32'h04);
    // frame error and start-bit glitch
    send(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    peek(4'h4, d);
    check("frame error", d, 32'h14);
    bus_wr(4'h4, 32'h10);
    peek(4'h4, d);
    check("frame error cleared", d, 32'h04);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    peek(4'h4, d);
    check("glitch ignored", d, 32'h04);
    // RX interrupt
    bus_wr(4'h8, 32'h1);
    send(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("irq on rx", 32'(irq), 32'h1);
    bus_rd(4'h0, d);
    check("rx 0xA5", d, 32'hA5);
    check("irq trails pop", 32'(irq), 32'h1);
    @(posedge clk);
    #1 check("irq clear after pop", 32'(irq), 32'h0);
    bus_wr(4'h8, 32'h0);
    // divisor clamp and reset mid-frame
    bus_wr(4'hC, 32'h2);
    bus_rd(4'hC, d);
    check("baud clamp", d, 32'h4);
    bus_wr(4'h0, 32'h00);
    repeat (10) @(negedge clk);
    check("tx low mid frame", 32'(tx), 32'h0);
    reset_n = 1'b0;
    #1 check("tx high on reset", 32'(tx), 32'h1);
    peek(4'hC, d);
    check("baud after reset", d, 32'd12);
    peek(4'h4, d);
    check("status in reset", d, 32'h04);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("tx idle after reset", 32'(tx), 32'h1);
    peek(4'h4, d);
    check("status after reset", d, 32'h04);
    check("irq after reset", 32'(irq), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
